// File: rtl/huffman_decode_pkg.sv
// Shared types and helpers for the Huffman receive-side decoder.
// Holds state/mode encodings, entry layout, symbol tags and the codeword lookup.
package huffman_decode_pkg;
  localparam int DEF_FREQ_W = 4;
  localparam int DEF_SYM_W  = 4;
  localparam int DEF_CNT_W  = 16;
  localparam int NUM_ENT    = 4;
  // Within an entry the symbol tag sits at the bottom, frequency directly above it
  localparam int SYM_LSB    = 0;

  localparam logic [3:0] SYM_A = 4'hA;
  localparam logic [3:0] SYM_B = 4'hB;
  localparam logic [3:0] SYM_C = 4'hC;
  localparam logic [3:0] SYM_D = 4'hD;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DECODE, S_EMIT} state_e;
  typedef enum logic {MODE_SKEW = 1'b0, MODE_BAL = 1'b1} mode_e;

  typedef struct packed {
    logic       done;
    logic [1:0] ent;
  } hit_t;

  // len is the codeword length including the newest bit, which sits in code[0]
  function automatic hit_t code_lookup(mode_e mode, logic [1:0] len, logic [2:0] code);
    hit_t h;
    h = '0;
    if (mode == MODE_BAL) begin
      if (len == 2'd2) begin
        h.done = 1'b1;
        h.ent  = 2'd3 - code[1:0];
      end
    end else begin
      case (len)
        2'd1: if (!code[0]) begin h.done = 1'b1; h.ent = 2'd3; end
        2'd2: if (code[1:0] == 2'b10) begin h.done = 1'b1; h.ent = 2'd2; end
        2'd3: begin h.done = 1'b1; h.ent = code[0] ? 2'd0 : 2'd1; end
        default: ;
      endcase
    end
    return h;
  endfunction
endpackage

// File: rtl/huffman_decode_if.sv
// Table/bitstream/symbol bundle between the channel, the decoder and the consumer.
interface huffman_decode_if
  import huffman_decode_pkg::*;
#(
  parameter int FREQ_W = DEF_FREQ_W,
  parameter int SYM_W  = DEF_SYM_W,
  parameter int CNT_W  = DEF_CNT_W
);
  logic [NUM_ENT*(FREQ_W+SYM_W)-1:0] table_in;
  logic              table_load;
  logic              bit_in;
  logic              bit_valid;
  logic              bit_ready;
  logic [SYM_W-1:0]  sym_out;
  logic              sym_valid;
  logic              sym_ready;
  logic              table_err;
  logic [CNT_W-1:0]  sym_cnt;

  modport master (output table_in, table_load, bit_in, bit_valid, sym_ready,
                  input  bit_ready, sym_out, sym_valid, table_err, sym_cnt);
  modport slave  (input  table_in, table_load, bit_in, bit_valid, sym_ready,
                  output bit_ready, sym_out, sym_valid, table_err, sym_cnt);
endinterface

// File: rtl/huffman_decode_tree_build.sv
// Combinational tree rebuild from the captured weight table: sort check,
// merged weight of the two lightest entries and tree shape selection.
module huffman_tree_build
  import huffman_decode_pkg::*;
#(
  parameter int FREQ_W = DEF_FREQ_W,
  parameter int SYM_W  = DEF_SYM_W
) (
  input  logic [NUM_ENT*(FREQ_W+SYM_W)-1:0] table_i,
  output logic                              sorted_o,
  output mode_e                             mode_o,
  output logic [NUM_ENT-1:0][SYM_W-1:0]     sym_o
);
  localparam int EW = FREQ_W + SYM_W;

  logic [NUM_ENT-1:0][FREQ_W-1:0] f;
  logic [FREQ_W:0]                s;

  always_comb begin
    for (int i = 0; i < NUM_ENT; i++) begin
      sym_o[i] = table_i[i*EW + SYM_LSB +: SYM_W];
      f[i]     = table_i[i*EW + SYM_LSB + SYM_W +: FREQ_W];
    end
    sorted_o = (f[0] <= f[1]) && (f[1] <= f[2]) && (f[2] <= f[3]);
    s        = {1'b0, f[0]} + {1'b0, f[1]};
    // When the merged pair does not outweigh the heaviest entry the tree is a chain
    mode_o   = (s <= {1'b0, f[3]}) ? MODE_SKEW : MODE_BAL;
  end
endmodule

// File: rtl/huffman_decode.sv
// Huffman bitstream decoder: rebuilds the 4-leaf tree from the sorted weight
// table, then walks serial code bits into symbol tags with valid/ready output.
module huffman_decode
  import huffman_decode_pkg::*;
#(
  parameter int FREQ_W = DEF_FREQ_W,
  parameter int SYM_W  = DEF_SYM_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  huffman_decode_if.slave  bus
);
  state_e state_q, state_d;
  mode_e  mode_q, mode_w;

  logic [NUM_ENT*(FREQ_W+SYM_W)-1:0] table_q;
  logic [NUM_ENT-1:0][SYM_W-1:0]     sym_w;
  logic                              sorted_w;
  logic [2:0]                        code_q;
  logic [1:0]                        len_q;
  logic [SYM_W-1:0]                  sym_q;
  logic [CNT_W-1:0]                  cnt_q;
  logic                              err_q;
  logic                              bit_acc;
  logic                              sym_hs;
  logic [2:0]                        code_nx;
  hit_t                              hit;

  huffman_tree_build #(.FREQ_W(FREQ_W), .SYM_W(SYM_W)) u_tree (
    .table_i  (table_q),
    .sorted_o (sorted_w),
    .mode_o   (mode_w),
    .sym_o    (sym_w)
  );

  assign bit_acc = bus.bit_valid && (state_q == S_DECODE);
  assign sym_hs  = bus.sym_ready && (state_q == S_EMIT);
  assign code_nx = {code_q[1:0], bus.bit_in};
  assign hit     = code_lookup(mode_q, len_q + 2'd1, code_nx);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.table_load) state_d = S_LOAD;
    else begin
      case (state_q)
        S_IDLE:   state_d = S_IDLE;
        S_LOAD:   state_d = sorted_w ? S_DECODE : S_IDLE;
        S_DECODE: if (bit_acc && hit.done) state_d = S_EMIT;
        S_EMIT:   if (bus.sym_ready) state_d = S_DECODE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.bit_ready = (state_q == S_DECODE);
    bus.sym_valid = (state_q == S_EMIT);
    bus.sym_out   = sym_q;
    bus.table_err = err_q;
    bus.sym_cnt   = cnt_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      table_q <= '0;
      mode_q  <= MODE_SKEW;
      code_q  <= '0;
      len_q   <= '0;
      sym_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      if (bus.table_load) table_q <= bus.table_in;

      if (state_q == S_LOAD && !bus.table_load) begin
        err_q <= !sorted_w;
        if (sorted_w) begin
          mode_q <= mode_w;
          cnt_q  <= '0;
        end
      end

      // Partial codewords never survive outside DECODE
      if (state_q != S_DECODE || hit.done) begin
        if (state_q != S_DECODE || bit_acc) begin
          code_q <= '0;
          len_q  <= '0;
        end
      end else if (bit_acc) begin
        code_q <= code_nx;
        len_q  <= len_q + 2'd1;
      end

      if (bit_acc && hit.done && !bus.table_load) sym_q <= sym_w[hit.ent];

      // A coincident table load clears the count instead
      if (sym_hs && !bus.table_load && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
    end
  end
endmodule
